countdown_cascade_ctrl: RTL and testbench

COUNTDOWN_CASCADE_CTRL -- requirements
Module: countdown_cascade_ctrl

---
 rtl/countdown_pkg.sv | 19 +
 rtl/bcd_digit_down.sv | 36 +++
 rtl/countdown_cascade_ctrl.sv | 109 ++++++++++
 tb/tb_countdown_cascade_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared definitions for the two-digit BCD countdown controller:
// FSM state encoding, the decimal digit ceiling and a clamp helper.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BCD_MAX = 9;

  // Saturate a 4-bit preset to the highest legal value of its digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade of a down-counter: synchronous load (clamped to DIGIT_MAX),
// decrement on enable, wraps 0 -> DIGIT_MAX and flags a borrow to the next
// digit in the same cycle the wrap happens.
module bcd_digit_down
  import countdown_pkg::*;
#(
  parameter int DIGIT_MAX = BCD_MAX
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic [3:0] digit,
  output logic       borrow_out
);

  localparam logic [3:0] MAX_VALUE = 4'(DIGIT_MAX);

  // Borrow is taken by the next-higher digit on the same edge as our wrap.
  always_comb begin
    borrow_out = enable && (digit == 4'd0);
  end

  // Digit register: load beats decrement.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= clamp_digit(load_value, MAX_VALUE);
    end else if (enable) begin
      digit <= (digit == 4'd0) ? MAX_VALUE : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_cascade_ctrl.sv
// Two-digit BCD countdown with IDLE/RUN/PAUSE/DONE control. Counts down one
// step per tick while running, stops at 00 with a one-cycle done_pulse and
// holds end_condition high until the next load.
module countdown_cascade_ctrl
  import countdown_pkg::*;
#(
  parameter int TENS_MAX = 9
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] preset_units,
  input  logic [3:0] preset_tens,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       running,
  output logic       end_condition,
  output logic       done_pulse
);

  state_t state_reg;
  state_t state_next;
  logic   running_next;
  logic   end_next;
  logic   pulse_next;
  logic   count_en;
  logic   units_borrow;
  logic   tens_borrow;

  // Next-state and next-output decode. Commands are prioritised
  // load > start > pause; a start while already running is the winning
  // command but has no effect, so pause is dropped and a tick still counts.
  always_comb begin
    state_next   = state_reg;
    count_en     = 1'b0;
    running_next = 1'b0;
    end_next     = 1'b0;
    pulse_next   = 1'b0;

    if (load) begin
      state_next = ST_IDLE;
    end else if (start) begin
      case (state_reg)
        ST_IDLE:  state_next = (units == 4'd0 && tens == 4'd0) ? ST_DONE : ST_RUN;
        ST_PAUSE: state_next = ST_RUN;
        ST_RUN:   count_en   = tick;
        default:  state_next = state_reg;
      endcase
    end else if (state_reg == ST_RUN) begin
      if (pause) begin
        state_next = ST_PAUSE;
      end else begin
        count_en = tick;
      end
    end

    // A decrement from 01 lands on 00: finish on that same edge.
    if (count_en && tens == 4'd0 && units == 4'd1) begin
      state_next = ST_DONE;
    end

    running_next = (state_next == ST_RUN);
    end_next     = (state_next == ST_DONE);
    pulse_next   = (state_next == ST_DONE) && (state_reg != ST_DONE);
  end

  // State and flag registers.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      running       <= 1'b0;
      end_condition <= 1'b0;
      done_pulse    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      running       <= running_next;
      end_condition <= end_next;
      done_pulse    <= pulse_next;
    end
  end

  bcd_digit_down #(.DIGIT_MAX(BCD_MAX)) u_units (
    .clock_in   (clock_in),
    .reset      (reset),
    .load       (load),
    .load_value (preset_units),
    .enable     (count_en),
    .digit      (units),
    .borrow_out (units_borrow)
  );

  // Tens never wraps: the count stops at 00, so its borrow is unused.
  bcd_digit_down #(.DIGIT_MAX(TENS_MAX)) u_tens (
    .clock_in   (clock_in),
    .reset      (reset),
    .load       (load),
    .load_value (preset_tens),
    .enable     (units_borrow),
    .digit      (tens),
    .borrow_out (tens_borrow)
  );

  logic unused_ok;
  assign unused_ok = tens_borrow;

endmodule

// File: tb/tb_countdown_cascade_ctrl.sv
// Bench for countdown_cascade_ctrl (TENS_MAX = 5): a table of directed
// vectors, hand-written multi-cycle sequences, then random commands checked
// against an integer-count reference model.
module tb_countdown_cascade_ctrl;

  localparam int TM = 5;

  logic       clock_in = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] preset_units = 4'd0, preset_tens = 4'd0;
  logic [3:0] units, tens;
  logic       running, end_condition, done_pulse;

  countdown_cascade_ctrl #(.TENS_MAX(TM)) dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .tick          (tick),
    .load          (load),
    .start         (start),
    .pause         (pause),
    .preset_units  (preset_units),
    .preset_tens   (preset_tens),
    .units         (units),
    .tens          (tens),
    .running       (running),
    .end_condition (end_condition),
    .done_pulse    (done_pulse)
  );

  always #5 clock_in = ~clock_in;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the count as a plain integer 0..(TM*10+9).
  int m_count = 0;
  int m_mode  = 0;     // 0 idle, 1 run, 2 pause, 3 done
  bit m_pulse = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_dec();
    m_count = m_count - 1;
    if (m_count == 0) begin
      m_mode  = 3;
      m_pulse = 1'b1;
    end
  endfunction

  function automatic void model_edge(bit l, bit s, bit p, bit t, int pu, int pt);
    m_pulse = 1'b0;
    if (l) begin
      m_count = ((pt > TM) ? TM : pt) * 10 + ((pu > 9) ? 9 : pu);
      m_mode  = 0;
    end else if (s) begin
      if (m_mode == 0) begin
        if (m_count == 0) begin
          m_mode  = 3;
          m_pulse = 1'b1;
        end else begin
          m_mode = 1;
        end
      end else if (m_mode == 2) begin
        m_mode = 1;
      end else if (m_mode == 1 && t) begin
        model_dec();
      end
    end else if (m_mode == 1) begin
      if (p) m_mode = 2;
      else if (t) model_dec();
    end
  endfunction

  task automatic model_check(input string tag);
    chk({tag, ".units"}, int'(units), m_count % 10);
    chk({tag, ".tens"}, int'(tens), m_count / 10);
    chk({tag, ".running"}, int'(running), int'(m_mode == 1));
    chk({tag, ".end_condition"}, int'(end_condition), int'(m_mode == 3));
    chk({tag, ".done_pulse"}, int'(done_pulse), int'(m_pulse));
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input string tag, input bit l, input bit s, input bit p, input bit t,
                      input int pu, input int pt);
    load = l; start = s; pause = p; tick = t;
    preset_units = 4'(pu); preset_tens = 4'(pt);
    @(posedge clock_in);
    model_edge(l, s, p, t, pu, pt);
    #1;
    model_check(tag);
    load = 0; start = 0; pause = 0; tick = 0;
  endtask

  typedef struct {
    bit l, s, p, t;
    int pu, pt;
    int eu, et;
    bit er, ee, ep;
  } vec_t;

  vec_t vecs[16];
  int   pulses;

  initial begin
    // ---------------- directed table ----------------
    vecs[0]  = '{1,0,0,0, 0,2,  0,2, 0,0,0};  // load 20
    vecs[1]  = '{0,1,0,0, 0,0,  0,2, 1,0,0};  // start
    vecs[2]  = '{0,0,0,1, 0,0,  9,1, 1,0,0};  // tick: borrow -> 19
    vecs[3]  = '{1,0,0,1, 12,7, 9,5, 0,0,0};  // load aborts run, clamp -> 59
    vecs[4]  = '{0,0,0,1, 0,0,  9,5, 0,0,0};  // tick in IDLE ignored
    vecs[5]  = '{1,0,0,0, 0,0,  0,0, 0,0,0};  // load 00
    vecs[6]  = '{0,1,0,0, 0,0,  0,0, 0,1,1};  // start at 00 -> DONE
    vecs[7]  = '{0,0,0,0, 0,0,  0,0, 0,1,0};  // pulse only once
    vecs[8]  = '{0,1,0,1, 0,0,  0,0, 0,1,0};  // start in DONE ignored
    vecs[9]  = '{1,0,0,0, 3,0,  3,0, 0,0,0};  // load 03 leaves DONE
    vecs[10] = '{0,1,0,0, 0,0,  3,0, 1,0,0};
    vecs[11] = '{0,0,0,1, 0,0,  2,0, 1,0,0};
    vecs[12] = '{0,0,0,1, 0,0,  1,0, 1,0,0};
    vecs[13] = '{0,0,0,1, 0,0,  0,0, 0,1,1};  // reach 00 -> DONE
    vecs[14] = '{0,0,1,1, 0,0,  0,0, 0,1,0};  // pause/tick in DONE ignored
    vecs[15] = '{0,0,0,0, 0,0,  0,0, 0,1,0};

    reset = 1'b0;
    repeat (2) @(posedge clock_in);
    #1;
    chk("reset.units", int'(units), 0);
    chk("reset.tens", int'(tens), 0);
    chk("reset.running", int'(running), 0);
    chk("reset.end_condition", int'(end_condition), 0);
    chk("reset.done_pulse", int'(done_pulse), 0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step($sformatf("vec%0d", i), vecs[i].l, vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].pu, vecs[i].pt);
      chk($sformatf("vec%0d.units", i), int'(units), vecs[i].eu);
      chk($sformatf("vec%0d.tens", i), int'(tens), vecs[i].et);
      chk($sformatf("vec%0d.running", i), int'(running), int'(vecs[i].er));
      chk($sformatf("vec%0d.end", i), int'(end_condition), int'(vecs[i].ee));
      chk($sformatf("vec%0d.pulse", i), int'(done_pulse), int'(vecs[i].ep));
    end

    // ---------------- 12 down to 00 ----------------
    step("c12.load", 1, 0, 0, 0, 2, 1);
    step("c12.start", 0, 1, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      step("c12.tick", 0, 0, 0, 1, 0, 0);
      chk("c12.count", int'(tens) * 10 + int'(units), 12 - i);
      chk("c12.end", int'(end_condition), int'(i == 12));
      pulses += int'(done_pulse);
      step("c12.gap", 0, 0, 0, 0, 0, 0);
      pulses += int'(done_pulse);
    end
    chk("c12.pulse_count", pulses, 1);

    // ---------------- pause with a simultaneous tick ----------------
    step("p35.load", 1, 0, 0, 0, 5, 3);
    step("p35.start", 0, 1, 0, 0, 0, 0);
    step("p35.t1", 0, 0, 0, 1, 0, 0);
    step("p35.t2", 0, 0, 0, 1, 0, 0);
    step("p35.pause", 0, 0, 1, 1, 0, 0);
    chk("p35.after_pause", int'(tens) * 10 + int'(units), 33);
    chk("p35.paused_running", int'(running), 0);
    for (int i = 0; i < 3; i++) step("p35.held", 0, 0, 0, 1, 0, 0);
    chk("p35.held_count", int'(tens) * 10 + int'(units), 33);
    step("p35.resume", 0, 1, 0, 0, 0, 0);
    chk("p35.resumed_running", int'(running), 1);
    step("p35.t3", 0, 0, 0, 1, 0, 0);
    chk("p35.final", int'(tens) * 10 + int'(units), 32);

    // ---------------- asynchronous reset mid-run ----------------
    step("r47.load", 1, 0, 0, 0, 7, 4);
    step("r47.start", 0, 1, 0, 0, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    m_count = 0; m_mode = 0; m_pulse = 1'b0;
    chk("r47.async_units", int'(units), 0);
    chk("r47.async_tens", int'(tens), 0);
    chk("r47.async_running", int'(running), 0);
    chk("r47.async_pulse", int'(done_pulse), 0);
    @(posedge clock_in);
    #2;
    reset = 1'b1;
    step("r47.load_start", 1, 1, 0, 0, 7, 4);
    chk("r47.loaded", int'(tens) * 10 + int'(units), 47);
    chk("r47.idle_running", int'(running), 0);

    // ---------------- random against the model ----------------
    for (int i = 0; i < 800; i++) begin
      bit l, s, p, t;
      int pu, pt;
      l  = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 1) == 1);
      pu = $urandom_range(0, 15);
      pt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
      step("rand", l, s, p, t, pu, pt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
